// File: rtl/alu_pkg.sv
// Shared ALU definitions: ALUCtrl codes, FSM state encoding and a shift-code helper.
// Also consumed by the ALU control decoder so both sides agree on the encodings.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0011;
    localparam logic [3:0] ALU_SLL = 4'b0100;
    localparam logic [3:0] ALU_SRL = 4'b0101;
    localparam logic [3:0] ALU_BEQ = 4'b0110;
    localparam logic [3:0] ALU_XOR = 4'b0111;
    localparam logic [3:0] ALU_BNE = 4'b1001;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } alu_state_e;

    function automatic logic is_shift(input logic [3:0] code);
        return (code == ALU_SLL) || (code == ALU_SRL);
    endfunction

endpackage

// File: rtl/alu_comb_core.sv
// Single-cycle ALU datapath: logic ops, add/sub, branch compares and illegal-code detect.
// Shift codes are legal here but produce 0; the sequencer supplies shift results itself.
module alu_comb_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       i_ctrl,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_result,
    output logic             o_zero,
    output logic             o_illegal
);

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;

    assign w_sum  = i_a + i_b;
    assign w_diff = i_a - i_b;

    always_comb begin
        o_result  = '0;
        o_zero    = 1'b0;
        o_illegal = 1'b0;
        case (i_ctrl)
            ALU_AND: begin
                o_result = i_a & i_b;
                o_zero   = (o_result == '0);
            end
            ALU_OR: begin
                o_result = i_a | i_b;
                o_zero   = (o_result == '0);
            end
            ALU_XOR: begin
                o_result = i_a ^ i_b;
                o_zero   = (o_result == '0);
            end
            ALU_ADD: begin
                o_result = w_sum;
                o_zero   = (w_sum == '0);
            end
            ALU_SUB: begin
                o_result = w_diff;
                o_zero   = (w_diff == '0);
            end
            ALU_BEQ: begin
                o_result = w_diff;
                o_zero   = (w_diff == '0);
            end
            // BNE flags "taken" when the operands differ.
            ALU_BNE: begin
                o_result = w_diff;
                o_zero   = (w_diff != '0);
            end
            ALU_SLL, ALU_SRL: begin
                o_result = '0;
                o_zero   = 1'b0;
            end
            default: begin
                o_illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle execute-stage ALU with valid/ready request and result channels.
// Build option SEQ_ALU_FAST_SHIFT_EN replaces the 1-bit-per-cycle shifter with a barrel shifter.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [3:0]       ALUCtrl_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             illegal_o,
    output logic             result_valid_o,
    input  logic             result_ready_i
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    // req_ready_o is high only in IDLE; result_valid_o is high only in DONE and its
    // payload holds until result_ready_i is seen.

    alu_state_e       r_state;
    logic             r_req_ready;
    logic             r_result_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_illegal;

    logic [SHAMT_W-1:0] w_shamt;
    logic               w_is_shift;
    logic [WIDTH-1:0]   w_core_result;
    logic               w_core_zero;
    logic               w_core_illegal;

    assign w_shamt    = src2_i[SHAMT_W-1:0];
    assign w_is_shift = is_shift(ALUCtrl_i);

    alu_comb_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .i_ctrl   (ALUCtrl_i),
        .i_a      (src1_i),
        .i_b      (src2_i),
        .o_result (w_core_result),
        .o_zero   (w_core_zero),
        .o_illegal(w_core_illegal)
    );

`ifdef SEQ_ALU_FAST_SHIFT_EN
    logic [WIDTH-1:0] w_barrel;

    assign w_barrel = (ALUCtrl_i == ALU_SLL) ? (src1_i << w_shamt) : (src1_i >> w_shamt);
`else
    logic [WIDTH-1:0]   r_work;
    logic [SHAMT_W-1:0] r_cnt;
    logic               r_left;
    logic [WIDTH-1:0]   w_next_work;

    assign w_next_work = r_left ? (r_work << 1) : (r_work >> 1);
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state        <= IDLE;
            r_req_ready    <= 1'b1;
            r_result_valid <= 1'b0;
            r_result       <= '0;
            r_zero         <= 1'b0;
            r_illegal      <= 1'b0;
`ifndef SEQ_ALU_FAST_SHIFT_EN
            r_work         <= '0;
            r_cnt          <= '0;
            r_left         <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid_i && r_req_ready) begin
                        r_req_ready <= 1'b0;
                        if (w_is_shift) begin
`ifdef SEQ_ALU_FAST_SHIFT_EN
                            r_result       <= w_barrel;
                            r_zero         <= (w_barrel == '0);
                            r_illegal      <= 1'b0;
                            r_result_valid <= 1'b1;
                            r_state        <= DONE;
`else
                            if (w_shamt == '0) begin
                                r_result       <= src1_i;
                                r_zero         <= (src1_i == '0);
                                r_illegal      <= 1'b0;
                                r_result_valid <= 1'b1;
                                r_state        <= DONE;
                            end else begin
                                r_work  <= src1_i;
                                r_cnt   <= w_shamt;
                                r_left  <= (ALUCtrl_i == ALU_SLL);
                                r_state <= SHIFT;
                            end
`endif
                        end else begin
                            r_result       <= w_core_result;
                            r_zero         <= w_core_zero;
                            r_illegal      <= w_core_illegal;
                            r_result_valid <= 1'b1;
                            r_state        <= DONE;
                        end
                    end
                end
`ifndef SEQ_ALU_FAST_SHIFT_EN
                SHIFT: begin
                    r_work <= w_next_work;
                    r_cnt  <= r_cnt - SHAMT_W'(1);
                    // Counter value 1 means this edge performs the final shift.
                    if (r_cnt == SHAMT_W'(1)) begin
                        r_result       <= w_next_work;
                        r_zero         <= (w_next_work == '0);
                        r_illegal      <= 1'b0;
                        r_result_valid <= 1'b1;
                        r_state        <= DONE;
                    end
                end
`endif
                DONE: begin
                    if (result_ready_i) begin
                        r_result_valid <= 1'b0;
                        r_req_ready    <= 1'b1;
                        r_state        <= IDLE;
                    end
                end
                default: begin
                    r_state        <= IDLE;
                    r_req_ready    <= 1'b1;
                    r_result_valid <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready_o    = r_req_ready;
    assign result_valid_o = r_result_valid;
    assign result_o       = r_result;
    assign zero_o         = r_zero;
    assign illegal_o      = r_illegal;

endmodule
